// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-side definitions: enable/reset encodings, bus types, IF/ID record.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents:
//   RstEnable / ChipEna / ChipDisa / Stop / NoStop  single-bit encodings
//   ZeroWord                                        all-zero bus word
//   inst_addr_t / inst_t                            32-bit address and instruction buses
//   if_id_t                                         packed IF/ID pipeline record
//   word_align / next_seq_pc                        PC helper functions
package if_fetch_stage_pkg;

  localparam int InstAddrWidth = 32;
  localparam int InstWidth     = 32;

  typedef logic [InstAddrWidth-1:0] inst_addr_t;
  typedef logic [InstWidth-1:0]     inst_t;

  localparam logic       RstEnable = 1'b1;
  localparam logic       ChipEna   = 1'b1;
  localparam logic       ChipDisa  = 1'b0;
  localparam logic       Stop      = 1'b1;
  localparam logic       NoStop    = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Default byte increment between sequential fetches.
  localparam int PcStepDefault = 4;

  // What decode sees: the fetched word and the address it came from.
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

  localparam if_id_t IfIdBubble = '{pc: ZeroWord, inst: ZeroWord};

  // Instruction memory is word indexed, so the two byte-offset bits are
  // always cleared. Masking the whole word keeps every input bit in use.
  function automatic inst_addr_t word_align(input inst_addr_t addr);
    return addr & ~inst_addr_t'(3);
  endfunction

  // Sequential successor; natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
  function automatic inst_addr_t next_seq_pc(input inst_addr_t pc, input int step);
    return pc + inst_addr_t'(step);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id.sv
// IF/ID pipeline register with flush > stall_id > stall_if-bubble > capture priority.
// Latency: one cycle from fetch inputs to id_pc/id_inst.
// Backpressure: stall_id holds the held word; stall_if alone injects a NOP bubble.
//
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   flush             replace the held word with a bubble (highest priority)
//   stall_id          hold the held word
//   stall_if          fetch frozen while decode advances: insert a bubble
//   in_vld            fetch enabled this cycle (ROM chip enable)
//   in_pc, in_inst    address and instruction from the fetch side
//   id_pc, id_inst    registered record for decode
module if_fetch_stage_if_id
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_id,
  input  logic        stall_if,
  input  logic        in_vld,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  if_id_t if_id_q;
  if_id_t if_id_d;
  if_id_t capture;

  // With the ROM disabled its data pins are meaningless, so a zero word is
  // captured instead of whatever is floating on rom_inst.
  always_comb begin
    capture.pc   = in_pc;
    capture.inst = in_vld ? in_inst : ZeroWord;
  end

  always_comb begin
    if_id_d = if_id_q;
    if (flush == Stop) begin
      if_id_d = IfIdBubble;
    end else if (stall_id == Stop) begin
      if_id_d = if_id_q;
    end else if (stall_if == Stop) begin
      // Fetch is frozen but decode moves on: hand it a NOP so the frozen
      // instruction is not decoded twice.
      if_id_d = IfIdBubble;
    end else begin
      if_id_d = capture;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      if_id_q <= IfIdBubble;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign id_pc   = if_id_q.pc;
  assign id_inst = if_id_q.inst;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns PC and ROM enable, feeds the IF/ID register.
// Latency: address presented in cycle N, instruction at id_inst after edge N+1.
// Backpressure: stall_if holds the PC (branches still redirect); stall_id holds IF/ID.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   stall_if, stall_id       stall controls from the hazard unit
//   flush                    squash the instruction in IF/ID
//   branch_flag/target       PC redirect request and byte target
//   rom_inst                 combinational ROM read data
//   rom_ce, rom_addr         ROM chip enable and byte address (== pc)
//   id_pc, id_inst           decode-side PC and instruction
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = PcStepDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        flush,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic [31:0] rom_inst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  logic       ce_q;
  logic       ce_d;
  inst_addr_t pc_q;
  inst_addr_t pc_d;

  // The ROM comes up one edge after reset release; it stays on until the
  // next reset.
  always_comb begin
    ce_d = ChipEna;
  end

  always_comb begin
    pc_d = pc_q;
    if (ce_q == ChipDisa) begin
      // Pinning the PC here makes RESET_PC the first address fetched and
      // keeps it on the bus for a full enabled cycle before any increment.
      pc_d = RESET_PC;
    end else if (branch_flag) begin
      // A branch resolved in ID is taken even while IF is stalled, otherwise
      // the redirect would be lost when the stall releases.
      pc_d = word_align(branch_target);
    end else if (stall_if == Stop) begin
      pc_d = pc_q;
    end else begin
      pc_d = next_seq_pc(pc_q, PC_STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      ce_q <= ChipDisa;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ce_d;
      pc_q <= pc_d;
    end
  end

  assign rom_ce   = ce_q;
  assign rom_addr = pc_q;

  if_fetch_stage_if_id u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall_id (stall_id),
    .stall_if (stall_if),
    .in_vld   (ce_q),
    .in_pc    (pc_q),
    .in_inst  (rom_inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_if = 1'b0;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;

  typedef struct {
    int          cyc;
    int          tag;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] ipc;
    logic [31:0] iinst;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ROM model: inst_mem[k] = 0x3400_0000 + k; junk on the data pins while disabled.
  assign rom_inst = rom_ce ? (32'h3400_0000 + {2'b00, rom_addr[31:2]}) : 32'hDEAD_BEEF;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush         (flush),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_inst      (rom_inst),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
  );

  task automatic chk(input int tag, input logic ce, input logic [31:0] addr,
                     input logic [31:0] ipc, input logic [31:0] iinst);
    checks++;
    if (rom_ce !== ce || rom_addr !== addr || id_pc !== ipc || id_inst !== iinst) begin
      errors++;
      $display("FAIL step%0d: got ce=%b addr=%h id_pc=%h id_inst=%h, want ce=%b addr=%h id_pc=%h id_inst=%h",
               tag, rom_ce, rom_addr, id_pc, id_inst, ce, addr, ipc, iinst);
    end
  endtask

  // Monitor: compares every expectation due for the cycle just completed.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cycle_cnt) begin
        checks++;
        errors++;
        $display("FAIL step%0d: expectation missed, cycle %0d vs due %0d", e.tag, cycle_cnt, e.cyc);
      end else begin
        chk(e.tag, e.ce, e.addr, e.ipc, e.iinst);
      end
    end
  end

  // Drive inputs for one cycle and queue the state expected after the next edge.
  task automatic step(input int tag, input logic sif, input logic sid, input logic fl,
                      input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_addr, input logic [31:0] e_pc, input logic [31:0] e_inst);
    exp_t e;
    stall_if      = sif;
    stall_id      = sid;
    flush         = fl;
    branch_flag   = br;
    branch_target = tgt;
    e.cyc   = cycle_cnt + 1;
    e.tag   = tag;
    e.ce    = 1'b1;
    e.addr  = e_addr;
    e.ipc   = e_pc;
    e.iinst = e_inst;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset for 3 edges, then run sequentially.
    repeat (3) @(posedge clk);
    #1;
    chk(0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    rst = 1'b0;
    //    tag sif  sid  fl   br   target          addr           id_pc          id_inst
    step(1,  0,   0,   0,   0,   32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    step(2,  0,   0,   0,   0,   32'h0,          32'h0000_0004, 32'h0000_0000, 32'h3400_0000);
    step(3,  0,   0,   0,   0,   32'h0,          32'h0000_0008, 32'h0000_0004, 32'h3400_0001);
    step(4,  0,   0,   0,   0,   32'h0,          32'h0000_000C, 32'h0000_0008, 32'h3400_0002);
    step(5,  0,   0,   0,   0,   32'h0,          32'h0000_0010, 32'h0000_000C, 32'h3400_0003);
    // 2. Full stall for two cycles at pc=0x10.
    step(6,  1,   1,   0,   0,   32'h0,          32'h0000_0010, 32'h0000_000C, 32'h3400_0003);
    step(7,  1,   1,   0,   0,   32'h0,          32'h0000_0010, 32'h0000_000C, 32'h3400_0003);
    step(8,  0,   0,   0,   0,   32'h0,          32'h0000_0014, 32'h0000_0010, 32'h3400_0004);
    // 3. IF-only stall: bubble into IF/ID, pc holds.
    step(9,  1,   0,   0,   0,   32'h0,          32'h0000_0014, 32'h0000_0000, 32'h0000_0000);
    step(10, 0,   0,   0,   0,   32'h0,          32'h0000_0018, 32'h0000_0014, 32'h3400_0005);
    step(11, 0,   0,   0,   0,   32'h0,          32'h0000_001C, 32'h0000_0018, 32'h3400_0006);
    step(12, 0,   0,   0,   0,   32'h0,          32'h0000_0020, 32'h0000_001C, 32'h3400_0007);
    // 4. Branch at pc=0x20 to 0x102 (aligned to 0x100); then branch under stall_if.
    step(13, 0,   0,   0,   1,   32'h0000_0102,  32'h0000_0100, 32'h0000_0020, 32'h3400_0008);
    step(14, 0,   0,   0,   0,   32'h0,          32'h0000_0104, 32'h0000_0100, 32'h3400_0040);
    step(15, 1,   0,   0,   1,   32'h0000_0102,  32'h0000_0100, 32'h0000_0000, 32'h0000_0000);
    step(16, 0,   0,   0,   0,   32'h0,          32'h0000_0104, 32'h0000_0100, 32'h3400_0040);
    // 5. Flush beats stall_id; flush with branch.
    step(17, 1,   1,   1,   0,   32'h0,          32'h0000_0104, 32'h0000_0000, 32'h0000_0000);
    step(18, 0,   0,   0,   0,   32'h0,          32'h0000_0108, 32'h0000_0104, 32'h3400_0041);
    step(19, 0,   0,   1,   1,   32'h0000_0200,  32'h0000_0200, 32'h0000_0000, 32'h0000_0000);
    step(20, 0,   0,   0,   0,   32'h0,          32'h0000_0204, 32'h0000_0200, 32'h3400_0080);
    // 6. Branch to the top word (low bits set in target) and wrap to 0.
    step(21, 0,   0,   0,   1,   32'hFFFF_FFFF,  32'hFFFF_FFFC, 32'h0000_0204, 32'h3400_0081);
    step(22, 0,   0,   0,   0,   32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 32'h73FF_FFFF);
    step(23, 0,   0,   0,   0,   32'h0,          32'h0000_0004, 32'h0000_0000, 32'h3400_0000);
    // Let the monitor drain before asserting reset between edges.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(24, 1'b0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    chk(25, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    step(26, 0,   0,   0,   0,   32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    step(27, 0,   0,   0,   0,   32'h0,          32'h0000_0004, 32'h0000_0000, 32'h3400_0000);
    step(28, 0,   0,   0,   0,   32'h0,          32'h0000_0008, 32'h0000_0004, 32'h3400_0001);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch initiator for the 5-stage MIPS pipeline. It drives the instruction ROM, owning the PC, chip-enable and address. The ROM is combinational: it returns the instruction in the same cycle as the address.
The block registers the returned instruction and its PC into the IF/ID pipeline register for decode. It also handles pipeline stalls, branch redirects and flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on the first enabled cycle after reset.
PC_STEP, 4, byte increment per sequential fetch (MIPS byte addressing).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall_if  in  1  hold the PC (from stall controller).
stall_id  in  1  hold the IF/ID register.
flush  in  1  kill the instruction in IF/ID (exception/branch-likely squash).
branch_flag  in  1  redirect the PC this cycle.
branch_target  in  32  redirect byte address.
rom_inst  in  32  instruction returned by the ROM.
rom_ce  out  1  ROM chip enable (ChipEna/ChipDisa).
rom_addr  out  32  byte address to the ROM; equals pc.
id_pc  out  32  PC of the instruction held for decode.
id_inst  out  32  instruction held for decode.

Behaviour:
- Reset (async, rst=1): rom_ce=ChipDisa, pc=RESET_PC, id_pc=ZeroWord, id_inst=ZeroWord. Reset asserted mid-operation clears all state immediately, with no completion of the in-flight fetch.
- ce bring-up:
  - The first rising edge with rst=0 sets rom_ce=ChipEna.
  - While rom_ce=ChipDisa, pc is forced to RESET_PC.
  - So the first fetched address is RESET_PC, and it holds for one enabled cycle before any increment.
- PC update each edge while rom_ce=ChipEna, priority high to low:
  - branch_flag=1: pc<=branch_target with bits [1:0] forced to 00. This applies even if stall_if=1, because a branch resolved in ID is never lost.
  - Otherwise, if stall_if=1: pc holds.
  - Otherwise: pc<=pc+PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- rom_addr = pc, purely combinational. The ROM indexes the word with addr[N+1:2]; low bits are always 00.
- IF/ID register each edge, priority high to low:
  - flush=1: id_pc<=ZeroWord, id_inst<=ZeroWord (a NOP bubble).
  - Otherwise, stall_id=1: hold both.
  - Otherwise, stall_if=1: insert a bubble (zeros), because IF is frozen but ID advances.
  - Otherwise: id_pc<=pc, id_inst<=rom_inst.
- While rom_ce=ChipDisa, the captured instruction is ZeroWord regardless of rom_inst.
- Latency: the address is presented in cycle N; the instruction is visible at id_inst after edge N+1. Throughput is one instruction per cycle with no stalls.
- Simultaneous events:
  - flush together with branch_flag: the bubble goes into IF/ID and pc takes the target.
  - flush together with stall_id: flush wins.
  - Stall bits are only ever asserted monotonically toward the front (stall_id implies stall_if). The block does not check this.

Decomposition:
- Shared header define.v provides RstEnable, ChipEna/ChipDisa, ZeroWord, InstAddrBus[31:0], InstBus[31:0], Stop/NoStop and the PC_STEP constant.
- One natural sub-module, if_id, holding the IF/ID register and its flush/stall/bubble priority. The PC/ce logic stays in the top module.

Test Plan:
1. Reset and run: rst high 3 cycles, then low; ROM preloaded so that inst_mem[k]=0x3400_0000+k.
   - rom_ce rises on the first edge; rom_addr sequence is 0,0,4,8,C.
   - id_inst follows one cycle later: 0,0x34000000,0x34000001,...
2. Stall: stall_if=stall_id=1 for 2 cycles at pc=0x10.
   - rom_addr holds at 0x10; id_pc/id_inst hold.
   - After release, the sequence resumes at 0x14 with no duplicate or skipped instruction.
3. IF-only stall: stall_if=1, stall_id=0 for 1 cycle.
   - id_inst=0 and id_pc=0 (bubble) for that cycle; pc holds.
4. Branch: branch_flag=1, branch_target=0x0000_0102 at pc=0x20.
   - Next rom_addr=0x100; the following one is 0x104.
   - branch_flag during stall_if=1 still redirects to 0x100.
5. Flush: flush=1 with stall_id=1.
   - IF/ID becomes zeros the next cycle.
   - flush plus branch_flag: bubble in IF/ID, pc=target.
6. Wrap and async reset: branch to 0xFFFF_FFFC, then run; next rom_addr=0x0.
   - Assert rst between clock edges: rom_ce=0, rom_addr=RESET_PC, id_*=0 immediately, without waiting for the next edge.
